// File: rtl/ftoi_pipe.sv
`timescale 1ns/1ps
// ftoi_pipe: two-stage pipelined IEEE-754 single-precision to signed integer
// converter with rounding, saturation, invalid/inexact flags and a
// valid/ready handshake with full back-pressure.
//
// Parameters
//   INT_W        output integer width (8..64)
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     operand offered
//   in_ready     operand accepted this cycle when in_valid is high
//   in_data      IEEE-754 single operand
//   in_rm        rounding mode: 00 nearest/ties away, 01 nearest/ties even,
//                10 toward zero, 11 toward minus infinity
//   out_valid    result available
//   out_ready    consumer takes the result
//   out_data     signed two's-complement result
//   out_invalid  NaN, infinity or out-of-range input (result saturated)
//   out_inexact  result differs from the input value (never with invalid)
//
// Configuration
//   FTOI_PIPE_ROUND_MODE_EN  when defined, in_rm selects the rounding mode;
//                            otherwise in_rm is ignored and mode 00 is fixed.
module ftoi_pipe #(
    parameter int INT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [1:0]       in_rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_data,
    output logic             out_invalid,
    output logic             out_inexact
);

    // Aligned significand: INT_W integer bits above 23 fraction bits.
    localparam int W = INT_W + 23;
    localparam logic [7:0] INT_W8 = 8'(INT_W);

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_NAN  = 3'd1,
        CLS_INF  = 3'd2,
        CLS_OVF  = 3'd3,
        CLS_NORM = 3'd4
    } cls_t;

    localparam logic [INT_W-1:0] MAX_POS = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] MIN_NEG = {1'b1, {(INT_W-1){1'b0}}};

    // Pipeline state
    logic             v1;
    logic             v2;
    logic             s1_sign;
    cls_t             s1_cls;
    logic [INT_W-1:0] s1_int;
    logic             s1_guard;
    logic             s1_sticky;
`ifdef FTOI_PIPE_ROUND_MODE_EN
    logic [1:0]       s1_rm;
`else
    logic             unused_rm;
    assign unused_rm = ^in_rm;
`endif

    // Handshake
    logic s2_load;
    logic s1_load;

    assign s2_load   = ~v2 | out_ready;
    assign s1_load   = ~v1 | s2_load;
    assign in_ready  = ~rst & s1_load;
    assign out_valid = v2;

    // Decode signals
    logic [7:0]       d_exp;
    logic [22:0]      d_man;
    logic [23:0]      d_sig;
    logic [7:0]       exp_unb;
    logic [W-1:0]     aligned;
    cls_t             d_cls;
    logic [INT_W-1:0] d_int;
    logic             d_guard;
    logic             d_sticky;

    // Stage-1 decode: classify the operand and align it to integer + guard + sticky.
    always_comb begin
        d_exp    = in_data[30:23];
        d_man    = in_data[22:0];
        d_sig    = {1'b1, d_man};
        exp_unb  = d_exp - 8'd127;
        // Only meaningful when 127 <= exp < 127 + INT_W, i.e. shift < 64.
        aligned  = {{(INT_W-1){1'b0}}, d_sig} << exp_unb[5:0];
        d_cls    = CLS_NORM;
        d_int    = {INT_W{1'b0}};
        d_guard  = 1'b0;
        d_sticky = 1'b0;
        if (d_exp == 8'd0) begin
            // Zero and denormals flush to exact zero.
            d_cls = CLS_ZERO;
        end else if (d_exp == 8'hFF) begin
            d_cls = (d_man != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (d_exp < 8'd126) begin
            // |value| < 0.5: below the guard position, only sticky survives.
            d_sticky = 1'b1;
        end else if (d_exp == 8'd126) begin
            // 0.5 <= |value| < 1: hidden bit lands on the guard position.
            d_guard  = 1'b1;
            d_sticky = |d_man;
        end else if (exp_unb >= INT_W8) begin
            // Magnitude >= 2^INT_W: cannot fit even before rounding.
            d_cls = CLS_OVF;
        end else begin
            d_int    = aligned[W-1:23];
            d_guard  = aligned[22];
            d_sticky = |aligned[21:0];
        end
    end

    // Stage-1 registers: capture the decoded operand whenever stage 1 can load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            s1_sign   <= 1'b0;
            s1_cls    <= CLS_ZERO;
            s1_int    <= {INT_W{1'b0}};
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
`ifdef FTOI_PIPE_ROUND_MODE_EN
            s1_rm     <= 2'b00;
`endif
        end else if (s1_load) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sign   <= in_data[31];
                s1_cls    <= d_cls;
                s1_int    <= d_int;
                s1_guard  <= d_guard;
                s1_sticky <= d_sticky;
`ifdef FTOI_PIPE_ROUND_MODE_EN
                s1_rm     <= in_rm;
`endif
            end
        end
    end

    // Round/saturate signals
    logic             up;
    logic [INT_W:0]   mag;
    logic [INT_W-1:0] mag_lo;
    logic             pos_ovf;
    logic             neg_ovf;
    logic [INT_W-1:0] r_data;
    logic             r_invalid;
    logic             r_inexact;

`ifdef FTOI_PIPE_ROUND_MODE_EN
    // Round-up decision for the selected mode.
    always_comb begin
        case (s1_rm)
            2'b00:   up = s1_guard;
            2'b01:   up = s1_guard & (s1_sticky | s1_int[0]);
            2'b10:   up = 1'b0;
            2'b11:   up = (s1_guard | s1_sticky) & s1_sign;
            default: up = s1_guard;
        endcase
    end
`else
    // Round-up decision: nearest, ties away from zero.
    always_comb begin
        up = s1_guard;
    end
`endif

    // Stage-2 compute: round, range check on the rounded magnitude, negate, saturate.
    always_comb begin
        mag     = {1'b0, s1_int} + {{INT_W{1'b0}}, up};
        mag_lo  = mag[INT_W-1:0];
        // Positive limit is 2^(INT_W-1)-1; negative limit is 2^(INT_W-1).
        pos_ovf = mag[INT_W] | mag[INT_W-1];
        neg_ovf = mag[INT_W] | (mag[INT_W-1] & (|mag[INT_W-2:0]));
        r_data    = {INT_W{1'b0}};
        r_invalid = 1'b0;
        r_inexact = 1'b0;
        case (s1_cls)
            CLS_ZERO: begin
                r_data    = {INT_W{1'b0}};
                r_invalid = 1'b0;
                r_inexact = 1'b0;
            end
            CLS_NAN: begin
                r_data    = MIN_NEG;
                r_invalid = 1'b1;
            end
            CLS_INF, CLS_OVF: begin
                r_data    = s1_sign ? MIN_NEG : MAX_POS;
                r_invalid = 1'b1;
            end
            CLS_NORM: begin
                if (s1_sign ? neg_ovf : pos_ovf) begin
                    r_data    = s1_sign ? MIN_NEG : MAX_POS;
                    r_invalid = 1'b1;
                end else begin
                    r_data    = s1_sign ? ((~mag_lo) + {{(INT_W-1){1'b0}}, 1'b1}) : mag_lo;
                    r_inexact = s1_guard | s1_sticky;
                end
            end
            default: begin
                r_data    = {INT_W{1'b0}};
                r_invalid = 1'b0;
                r_inexact = 1'b0;
            end
        endcase
    end

    // Stage-2 / output registers: load from stage 1 when empty or being drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2          <= 1'b0;
            out_data    <= {INT_W{1'b0}};
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
        end else if (s2_load) begin
            v2 <= v1;
            if (v1) begin
                out_data    <= r_data;
                out_invalid <= r_invalid;
                out_inexact <= r_inexact;
            end
        end
    end

endmodule
